// File: rtl/dro_pulse_sequencer.sv
// Turns queued timed set/reset commands into one-cycle DRO pulses and models the DRO storage bit.
// Define DRO_SEQ_GUARD_EN to enforce MIN_SEP cycles from a set pulse to the next reset pulse.
module dro_pulse_sequencer #(
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int MIN_SEP = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_op,
    input  logic [DW-1:0]          cmd_gap,
    output logic                   set,
    output logic                   reset,
    output logic                   exp_out,
    output logic                   stored,
    output logic                   sep_stretch,
    output logic [$clog2(DEPTH):0] pend_cnt,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, FIRE} state_e;

    state_e        state_q, state_d;
    logic [DW:0]   mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          op_q, op_d;
    logic          stored_q, stored_d;
    logic          full, empty, push, pop, hold, stretch_flag;
    logic [DW:0]   head;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign cmd_ready = !full;
    assign pend_cnt  = wr_ptr_q - rd_ptr_q;
    assign stored    = stored_q;

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_gap};
    end

`ifdef DRO_SEQ_GUARD_EN
    localparam int SW = $clog2(MIN_SEP + 1);

    logic [SW-1:0] since_set_q, since_set_d;
    logic          stretch_q, stretch_d;

    // Leaving WAIT now fires in the next cycle, i.e. since_set_q + 2 cycles after the set pulse.
    assign hold         = op_q && ((int'(since_set_q) + 2) < MIN_SEP);
    assign stretch_flag = stretch_q;

    always_comb begin
        since_set_d = since_set_q;
        if (set)                              since_set_d = '0;
        else if (int'(since_set_q) < MIN_SEP) since_set_d = since_set_q + 1'b1;
        stretch_d = stretch_q;
        if (pop || state_q == FIRE)                         stretch_d = 1'b0;
        else if (state_q == WAIT && cnt_q == '0 && hold)    stretch_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            since_set_q <= SW'(MIN_SEP);
            stretch_q   <= 1'b0;
        end else begin
            since_set_q <= since_set_d;
            stretch_q   <= stretch_d;
        end
    end
`else
    assign hold         = 1'b0;
    assign stretch_flag = 1'b0;
`endif

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        if (pop) begin
            cnt_d = head[DW-1:0];
            op_d  = head[DW];
        end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        stored_d = stored_q;
        if (set)        stored_d = 1'b1;
        else if (reset) stored_d = 1'b0;
    end

    // NOTE: every register below is updated with non-blocking assignments so all see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            stored_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            stored_q <= stored_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = WAIT;
            WAIT:    if (cnt_q == '0 && !hold) state_d = FIRE;
            FIRE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        set         = (state_q == FIRE) && !op_q;
        reset       = (state_q == FIRE) && op_q;
        exp_out     = reset && stored_q;
        sep_stretch = reset && stretch_flag;
        busy        = !empty || (state_q != IDLE);
    end
endmodule

// File: tb/tb_dro_pulse_sequencer.sv
// Scoreboard bench for dro_pulse_sequencer: pulse timing and DRO results come from a cycle-arithmetic model.
module tb_dro_pulse_sequencer;
    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int MIN_SEP = 5;
`ifdef DRO_SEQ_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_op = 1'b0;
    logic [DW-1:0]          cmd_gap = '0;
    logic                   cmd_ready, set, reset, exp_out, stored, sep_stretch, busy;
    logic [$clog2(DEPTH):0] pend_cnt;

    dro_pulse_sequencer #(.DW(DW), .DEPTH(DEPTH), .MIN_SEP(MIN_SEP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_gap(cmd_gap), .set(set), .reset(reset),
        .exp_out(exp_out), .stored(stored), .sep_stretch(sep_stretch),
        .pend_cnt(pend_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; "cycle n" is the period after edge n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int acc;   // edge at which the command was written
        int pop;   // edge at which the sequencer takes it
        int fire;  // cycle in which its pulse is high
        bit op;
        bit exp;
        bit str;
    } cmd_t;

    cmd_t all_cmds[$];
    cmd_t exp_q[$];
    int   prev_fire    = -10;
    int   last_set     = -1000;
    bit   model_stored = 1'b0;
    bit   chk_en       = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Sequencer is free the cycle after the previous pulse; pop costs one edge, WAIT gap+1 edges.
    function automatic void model_accept(input bit op, input int gap, input int k);
        cmd_t c;
        int   idle_at;
        idle_at = (k > prev_fire + 1) ? k : prev_fire + 1;
        c.acc  = k;
        c.pop  = idle_at + 1;
        c.fire = idle_at + 2 + gap;
        c.op   = op;
        c.str  = 1'b0;
        if (GUARD && op && c.fire < last_set + MIN_SEP) begin
            c.fire = last_set + MIN_SEP;
            c.str  = 1'b1;
        end
        c.exp        = op && model_stored;
        model_stored = !op;
        if (!op) last_set = c.fire;
        prev_fire = c.fire;
        all_cmds.push_back(c);
        exp_q.push_back(c);
    endfunction

    function automatic void model_flush();
        all_cmds.delete();
        exp_q.delete();
        prev_fire    = -10;
        last_set     = -1000;
        model_stored = 1'b0;
    endfunction

    // Monitor: per-cycle status checks plus in-order pulse scoreboard.
    initial forever begin
        int   pend;
        bit   bsy;
        bit   st;
        cmd_t e;
        @(negedge clk);
        #1;
        if (rst_n && chk_en) begin
            pend = 0;
            bsy  = 1'b0;
            st   = 1'b0;
            foreach (all_cmds[i]) begin
                if (all_cmds[i].acc <= cyc) pend++;
                if (all_cmds[i].pop <= cyc) pend--;
                if (all_cmds[i].pop <= cyc && cyc <= all_cmds[i].fire) bsy = 1'b1;
                if (all_cmds[i].fire < cyc) st = !all_cmds[i].op;
            end
            if (pend > 0) bsy = 1'b1;
            check("pend_cnt", int'(pend_cnt), pend);
            check("cmd_ready", int'(cmd_ready), int'(pend < DEPTH));
            check("busy", int'(busy), int'(bsy));
            check("stored", int'(stored), int'(st));
            check("set_and_reset", int'(set && reset), 0);
            if (set || reset) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse @cycle %0d: set=%0b reset=%0b, expected none", cyc, set, reset);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, e.fire);
                    check("pulse_op", int'(reset), int'(e.op));
                    check("exp_out", int'(exp_out), int'(e.exp));
                    check("sep_stretch", int'(sep_stretch), int'(e.str));
                end
            end else begin
                check("exp_out_idle", int'(exp_out), 0);
                check("sep_stretch_idle", int'(sep_stretch), 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input bit op, input int gap);
        int waited;
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_gap   = DW'(gap);
        while (!cmd_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout @cycle %0d: cmd_ready stuck at 0, expected 1", cyc);
        end else begin
            model_accept(op, gap, cyc + 1);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout @cycle %0d: %0d pulses outstanding, expected 0", cyc, exp_q.size());
            exp_q.delete();
        end
        idle(4);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_set"}, int'(set), 0);
        check({tag, "_reset"}, int'(reset), 0);
        check({tag, "_exp_out"}, int'(exp_out), 0);
        check({tag, "_stored"}, int'(stored), 0);
        check({tag, "_sep_stretch"}, int'(sep_stretch), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_pend_cnt"}, int'(pend_cnt), 0);
        check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog @cycle %0d: simulation did not finish, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(3);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Basic set, set/reset with long and short gap, lone reset, double set.
        push(0, 0);  idle(8);
        push(1, 10); idle(4);
        push(0, 0);  push(1, 10); drain();
        push(0, 0);  push(1, 0);  drain();
        push(1, 0);  drain();
        push(0, 0);  push(0, 0);  push(1, 3); drain();
        push(0, 1);  push(1, 1);  push(1, 2); drain();

        // Maximum gap counts fully.
        push(0, 0);  push(1, (1 << DW) - 1); drain();

        // Fill the FIFO while the head command waits out a long gap.
        push(0, 20); idle(3);
        push(1, 0);  push(0, 1); push(1, 2); push(0, 0);
        #1;
        check("fill_pend_cnt", int'(pend_cnt), DEPTH);
        check("fill_cmd_ready", int'(cmd_ready), 0);
        @(negedge clk);
        push(1, 0);
        drain();

        // Randomized command stream with bursts and idle gaps.
        for (int i = 0; i < 120; i++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 2));
            push(1'($urandom_range(0, 1)), gap);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
        end
        drain();

        // Reset in the middle of WAIT with three commands queued.
        push(0, 30); push(1, 1); push(0, 2); push(1, 0);
        idle(4);
        check("pre_reset_pend_cnt", int'(pend_cnt), 3);
        rst_n = 1'b0;
        model_flush();
        #1;
        check_quiet("midreset");
        idle(2);
        rst_n = 1'b1;
        idle(40);
        push(1, 0); push(0, 0); push(1, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
